mux_arb: RTL
============

# mux_arb

Parametrised, registered N-bit multiplexer with CH input channels, valid/ready handshakes on every channel, and a round-robin or fixed-select grant policy. It replaces the purely combinational four-way multiplexer wherever several producers share one consumer. Typical consumers are the register-file write port and the memory address path. Selection, handshake and output register live in one block, so the datapath sees one stable word per transfer.

## Interface
Parameters:
- N, 8, data width in bits.
- CH, 4, number of input channels, at least 2.
- SEL_W is a derived localparam, $clog2(CH). It is not overridable.

Ports:
- clk  in  1  Single clock. All state changes on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- in_data  in  CH*N  Flattened channel data. Channel k occupies bits [k*N +: N].
- in_valid  in  CH  Per-channel valid.
- in_ready  out  CH  Per-channel ready. At most one bit is high in any cycle.
- mode  in  1  Grant policy. 0 selects round-robin; 1 selects fixed select.
- sel  in  SEL_W  Selected channel when mode=1. Ignored when mode=0.
- out  out  N  Registered output data.
- out_ch  out  SEL_W  Index of the channel that produced out.
- out_valid  out  1  Output word valid.
- out_ready  in  1  Consumer accepts the output word.

## Operation
- The block has one output register, with fields out, out_ch and out_valid.
- accept = !out_valid || out_ready. The register can load whenever it is empty or is being drained in the same cycle.
- The grant g is combinational.
  - mode=0: g is the first channel with in_valid high, searching ptr+1, ptr+2, … with wrap modulo CH.
  - mode=1: g = sel if sel < CH and in_valid[sel] = 1. Otherwise there is no grant.
- in_ready[k] = accept && grant exists && k == g. All other in_ready bits are 0.
- A transfer happens when the granted channel's in_valid and in_ready are both high.
  - On a transfer: out <= in_data[g], out_ch <= g, out_valid <= 1, ptr <= g.
  - The pointer update applies in both modes.
- If out_valid && out_ready and there is no new transfer, out_valid <= 0. out and out_ch keep their last values.
- Stall: while out_valid && !out_ready, out, out_ch and out_valid hold, and all in_ready bits are 0.
- A mode or sel change takes effect in the same cycle's grant calculation. It has no effect on an already-registered word.
- ptr is an SEL_W-bit register and wraps from CH-1 to 0. For a CH that is not a power of 2, values of CH and above are never stored.
- Reset (asynchronous, any cycle, including mid-stall):
  - out = 0, out_ch = 0, out_valid = 0, ptr = CH-1, so channel 0 has first priority.
  - Any held word is dropped.
  - in_ready is 0 for the whole time rst is high.

## Timing
- Latency is 1 cycle. Data accepted on edge t appears on out with out_valid high after edge t.
- Throughput is 1 word per cycle while out_ready stays high.
- in_ready depends combinationally on in_valid, mode, sel and out_ready. There is no combinational path from in_data to out.
- Round-robin fairness: with all channels continuously valid and out_ready high, each channel is granted exactly once in every CH consecutive transfers.
- The first rising edge after rst deasserts can perform a transfer.

## Test plan
Every scenario uses N=8, CH=4 and in_data = {0A, A0, 00, AA} for channels 3..0.

1. Reset, then mode=0, all in_valid=1111, out_ready=1.
   - out must read AA, 00, A0, 0A, AA on consecutive cycles.
   - out_ch must read 0, 1, 2, 3, 0.
   - Exactly one in_ready bit is high each cycle.
2. mode=1, sel stepped 0→1→2→3 every 2 cycles, all valid, out_ready=1.
   - out follows AA, 00, A0, 0A, each value lasting 2 cycles, each appearing 1 cycle after its sel change.
   - in_ready equals the one-hot of sel.
3. Backpressure: mode=0, in_valid=0101, out_ready=0 for 3 cycles, then 1.
   - out = AA with out_valid=1 holds for all 3 stalled cycles, and in_ready=0000 throughout.
   - After release, out must read A0, then AA.
4. Sparse round-robin: ptr=2 (after a grant to channel 2), in_valid=0011.
   - The next grant is channel 0, with out = AA.
   - The following grant is channel 1, with out = 00.
5. mode=1 with in_valid[sel]=0 while the other channels are valid.
   - in_ready=0000, no transfer happens, and out_valid drops to 0 after the held word is drained.
6. Assert rst mid-stall while out_valid=1 and out_ready=0.
   - out, out_ch and out_valid go to 0 immediately, before the next clock edge.
   - After release with all channels valid, the first output is AA with out_ch=0.

Source files
------------

// File: rtl/mux_arb.sv
// Purpose: CH-way valid/ready multiplexer with round-robin or fixed-select grant into one output register.
// Latency: 1 cycle from input handshake to out/out_valid; one word per cycle while out_ready stays high.
// Backpressure: while the held word is stalled (out_valid && !out_ready) every in_ready is 0.
module mux_arb #(
    parameter int N = 8,
    parameter int CH = 4,
    localparam int SEL_W = $clog2(CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*N-1:0]   in_data,
    input  logic [CH-1:0]     in_valid,
    output logic [CH-1:0]     in_ready,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [N-1:0]      out,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef struct packed {
        logic [N-1:0]     dat;
        logic [SEL_W-1:0] ch;
        logic             vld;
    } out_reg_t;

    out_reg_t         oreg;
    logic [SEL_W-1:0] ptr;

    logic             accept;
    logic             rr_hit;
    logic [SEL_W-1:0] rr_g;
    logic [SEL_W-1:0] rr_idx;
    logic             fx_hit;
    logic             gnt_hit;
    logic [SEL_W-1:0] gnt;
    logic [N-1:0]     gnt_dat;
    logic             xfer;

    assign accept = !oreg.vld || out_ready;

    // Search ptr+1, ptr+2, ... wrapping at CH-1 so the last winner has lowest priority.
    always_comb begin
        rr_hit = 1'b0;
        rr_g   = '0;
        rr_idx = ptr;
        for (int i = 0; i < CH; i++) begin
            rr_idx = (rr_idx == SEL_W'(CH - 1)) ? '0 : rr_idx + 1'b1;
            if (!rr_hit && in_valid[rr_idx]) begin
                rr_hit = 1'b1;
                rr_g   = rr_idx;
            end
        end
    end

    always_comb begin
        fx_hit = 1'b0;
        if (int'(sel) < CH) begin
            fx_hit = in_valid[sel];
        end
    end

    assign gnt     = mode ? sel : rr_g;
    assign gnt_hit = mode ? fx_hit : rr_hit;
    assign gnt_dat = in_data[int'(gnt)*N +: N];

    always_comb begin
        in_ready = '0;
        if (!rst && accept && gnt_hit) begin
            in_ready[gnt] = 1'b1;
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oreg <= '0;
            ptr  <= SEL_W'(CH - 1);
        end else if (xfer) begin
            oreg.dat <= gnt_dat;
            oreg.ch  <= gnt;
            oreg.vld <= 1'b1;
            ptr      <= gnt;
        end else if (oreg.vld && out_ready) begin
            oreg.vld <= 1'b0;
        end
    end

    assign out       = oreg.dat;
    assign out_ch    = oreg.ch;
    assign out_valid = oreg.vld;

endmodule
